// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential unsigned restoring divider (2N-bit / N-bit)
//
// Divides a 2N-bit dividend by an N-bit divisor and produces one quotient bit
// per clock. Control uses a start/busy/done handshake.
//
// Optional feature macro: DIVIDER_DBZ_EARLY_EN
//   defined   - a zero divisor at start skips iteration and reports div_by_zero
//   undefined - div_by_zero is tied 0 and a zero divisor runs the full 2N steps
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request; dividend/divisor are sampled on the same edge
//   dividend     2N-bit unsigned dividend
//   divisor      N-bit unsigned divisor
//   busy         high while iterating (CALC)
//   done         one-cycle pulse; quotient/remainder valid
//   quotient     2N-bit registered quotient, held until next result
//   remainder    N-bit registered remainder, held until next result
//   div_by_zero  zero-divisor flag (macro builds only, else 0)

module restoring_divider #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CW = $clog2(2 * N) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(2 * N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  // Shift register: dividend bits leave at the MSB while quotient bits enter
  // at the LSB, so after 2N steps it holds the full quotient.
  logic [2*N-1:0] shreg;
  logic [N:0]     part_rem;
  logic [N-1:0]   dvsr;
  logic [CW-1:0]  step;

  logic [N:0]     rem_shift;
  logic [N:0]     rem_sub;
  logic           fits;
  logic [N:0]     rem_next;
  logic [2*N-1:0] quo_next;

  always_comb begin
    rem_shift = {part_rem[N-1:0], shreg[2*N-1]};
    rem_sub   = rem_shift - {1'b0, dvsr};
    fits      = (rem_shift >= {1'b0, dvsr});
    rem_next  = fits ? rem_sub : rem_shift;
    quo_next  = {shreg[2*N-2:0], fits};
  end

`ifdef DIVIDER_DBZ_EARLY_EN
  logic dbz_q;
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      part_rem  <= '0;
      dvsr      <= '0;
      step      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIVIDER_DBZ_EARLY_EN
      dbz_q     <= 1'b0;
`endif
    end else begin
      case (state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back
        // operation; the done pulse of the finishing op still lasts one cycle.
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            shreg    <= dividend;
            dvsr     <= divisor;
            part_rem <= '0;
            step     <= '0;
`ifdef DIVIDER_DBZ_EARLY_EN
            dbz_q    <= 1'b0;
            if (divisor == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= dividend[N-1:0];
              dbz_q     <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
`else
            state <= CALC;
            busy  <= 1'b1;
`endif
          end
        end

        CALC: begin
          shreg    <= quo_next;
          part_rem <= rem_next;
          step     <= step + 1'b1;
          if (step == LAST_STEP) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= quo_next;
            remainder <= rem_next[N-1:0];
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
